matrix_scan_capture: RTL

//  Receiving end of the 5x7 LED-matrix column-scan interface (m_col / m_line) driven by the game top level.

---
 rtl/matrix_scan_capture_pkg.sv | 16 +
 rtl/matrix_scan_capture_if.sv | 16 +
 rtl/matrix_scan_capture_scan_stability_filter.sv | 69 ++++++
 rtl/matrix_scan_capture.sv | 123 ++++++++++++
 4 files changed

// File: rtl/matrix_scan_capture_pkg.sv
// Shared sizes, FSM state type and one-hot helper for the 5x7 matrix scan receiver.
// Pure declarations: no latency, no flow control.
package matrix_scan_pkg;
    localparam int N_COL     = 5;
    localparam int N_LINE    = 7;
    localparam int FRAME_W   = N_COL * N_LINE;
    localparam int COL_IDX_W = $clog2(N_COL);

    typedef enum logic {SYNC, CAPTURE} scan_state_t;

    function automatic logic [N_COL-1:0] col_onehot(input logic [COL_IDX_W-1:0] idx);
        logic [N_COL-1:0] one;
        one = {{(N_COL-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction
endpackage

// File: rtl/matrix_scan_capture_if.sv
// Scan pins in, captured frame and status out; master drives the scan, slave is the receiver.
// Plain wires: no latency, no backpressure (scan is sampled every cycle).
interface matrix_scan_capture_if;
    logic [matrix_scan_pkg::N_COL-1:0]   m_col;
    logic [matrix_scan_pkg::N_LINE-1:0]  m_line;
    logic [matrix_scan_pkg::FRAME_W-1:0] frame;
    logic                                frame_valid;
    logic                                scan_err;
    logic                                locked;
    logic [7:0]                          frame_count;

    modport master (output m_col, m_line,
                    input  frame, frame_valid, scan_err, locked, frame_count);
    modport slave  (input  m_col, m_line,
                    output frame, frame_valid, scan_err, locked, frame_count);
endinterface

// File: rtl/matrix_scan_capture_scan_stability_filter.sv
// 2-flop synchroniser plus column acceptance; accept 2 cycles after a pin change, 2+STABLE_CYCLES
// with MATRIX_SCAN_STABILITY_FILTER_EN (glitch rejection). No backpressure: one-cycle accept pulse.
module scan_stability_filter
    import matrix_scan_pkg::*;
`ifdef MATRIX_SCAN_STABILITY_FILTER_EN
#(
    parameter int STABLE_CYCLES = 4
)
`endif
(
    input  logic              clk,
    input  logic              clr,
    input  logic [N_COL-1:0]  col_i,
    input  logic [N_LINE-1:0] line_i,
    output logic              acc_o,
    output logic [N_COL-1:0]  col_o,
    output logic [N_LINE-1:0] line_o
);
    logic [N_COL-1:0]  col_s1_q, col_s2_q;
    logic [N_LINE-1:0] line_s1_q, line_s2_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            col_s1_q  <= '0;
            col_s2_q  <= '0;
            line_s1_q <= '0;
            line_s2_q <= '0;
        end else begin
            col_s1_q  <= col_i;
            col_s2_q  <= col_s1_q;
            line_s1_q <= line_i;
            line_s2_q <= line_s1_q;
        end
    end

    assign col_o  = col_s2_q;
    assign line_o = line_s2_q;

`ifdef MATRIX_SCAN_STABILITY_FILTER_EN
    localparam int CNT_W = $clog2(STABLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts repeats of the synchronised sample; saturating one past the hit keeps the pulse single.
    always_comb begin
        cnt_d = '0;
        if ({col_s1_q, line_s1_q} == {col_s2_q, line_s2_q})
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign acc_o = (cnt_q == CNT_HIT) && (|col_s2_q);
`else
    logic [N_COL-1:0] col_prev_q;

    always_ff @(posedge clk) begin
        if (clr) col_prev_q <= '0;
        else     col_prev_q <= col_s2_q;
    end

    assign acc_o = (col_s2_q != col_prev_q) && (|col_s2_q);
`endif
endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds the 35-bit frame from the column scan; frame_valid 1 cycle after column 0 is accepted.
// No backpressure: pins sampled every cycle; MATRIX_SCAN_STABILITY_FILTER_EN adds glitch filtering.
module matrix_scan_capture
    import matrix_scan_pkg::*;
#(
`ifdef MATRIX_SCAN_STABILITY_FILTER_EN
    parameter int STABLE_CYCLES  = 4,
`endif
    parameter int TIMEOUT_CYCLES = 1_000_000
)(
    input  logic                 clk,
    input  logic                 clr,
    matrix_scan_capture_if.slave scan
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(N_COL - 1);

    logic              acc;
    logic [N_COL-1:0]  acc_col;
    logic [N_LINE-1:0] acc_line;

`ifdef MATRIX_SCAN_STABILITY_FILTER_EN
    scan_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
`else
    scan_stability_filter u_filter (
`endif
        .clk    (clk),
        .clr    (clr),
        .col_i  (scan.m_col),
        .line_i (scan.m_line),
        .acc_o  (acc),
        .col_o  (acc_col),
        .line_o (acc_line)
    );

    scan_state_t            state_q;
    logic [COL_IDX_W-1:0]   expect_q;
    logic [FRAME_W-1:0]     shadow_q, frame_q;
    logic                   fv_q, err_q, locked_q;
    logic [7:0]             count_q;
    logic [TMR_W-1:0]       timer_q;

    logic [FRAME_W-1:0]     col_bits, col_mask, shadow_wr;

    // Frame bit N_COL*L+C holds LED (line L, column C); lines are active-low on the pins.
    always_comb begin
        col_bits = '0;
        col_mask = '0;
        for (int l = 0; l < N_LINE; l++) begin
            for (int c = 0; c < N_COL; c++) begin
                col_mask[N_COL*l+c] = acc_col[c];
                col_bits[N_COL*l+c] = acc_col[c] & ~acc_line[l];
            end
        end
    end

    assign shadow_wr = (shadow_q & ~col_mask) | col_bits;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= SYNC;
            expect_q <= LAST_COL;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            count_q  <= '0;
            timer_q  <= '0;
        end else begin
            fv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                SYNC: begin
                    timer_q <= '0;
                    if (acc && acc_col == col_onehot(LAST_COL)) begin
                        state_q  <= CAPTURE;
                        expect_q <= LAST_COL - 1'b1;
                        locked_q <= 1'b1;
                        shadow_q <= col_bits;
                    end
                end
                CAPTURE: begin
                    if (acc) begin
                        timer_q <= '0;
                        if (acc_col == col_onehot(expect_q)) begin
                            shadow_q <= shadow_wr;
                            if (expect_q == '0) begin
                                frame_q  <= shadow_wr;
                                fv_q     <= 1'b1;
                                count_q  <= count_q + 1'b1;
                                expect_q <= LAST_COL;
                            end else begin
                                expect_q <= expect_q - 1'b1;
                            end
                        end else begin
                            err_q    <= 1'b1;
                            shadow_q <= '0;
                            locked_q <= 1'b0;
                            state_q  <= SYNC;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        err_q    <= 1'b1;
                        shadow_q <= '0;
                        locked_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= SYNC;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign scan.frame       = frame_q;
    assign scan.frame_valid = fv_q;
    assign scan.scan_err    = err_q;
    assign scan.locked      = locked_q;
    assign scan.frame_count = count_q;
endmodule
